// File: rtl/regfile_stream_port_if.sv
// Bundle of control, register-file and stream signals around the
// register-file access sequencer. The sequencer uses the master view;
// the surrounding environment (core, harness, bench) uses the slave view.
interface regfile_stream_port_if #(
  parameter int W = 8,
  parameter int D = 4
);
  // control
  logic         start;
  logic         mode;
  logic [D-1:0] start_addr;
  logic [D:0]   count;
  logic         busy;
  logic         done;
  // register file side
  logic [D-1:0] rf_addr;
  logic         rf_write_en;
  logic [W-1:0] rf_wdata;
  logic [W-1:0] rf_rdata;
  // dump stream
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  // load stream
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;

  modport master (
    input  start, mode, start_addr, count, rf_rdata, out_ready, in_valid, in_data,
    output busy, done, rf_addr, rf_write_en, rf_wdata, out_valid, out_data, in_ready
  );

  modport slave (
    output start, mode, start_addr, count, rf_rdata, out_ready, in_valid, in_data,
    input  busy, done, rf_addr, rf_write_en, rf_wdata, out_valid, out_data, in_ready
  );
endinterface

// File: rtl/regfile_stream_port.sv
// Register-file access sequencer: dumps a contiguous run of registers onto
// a valid/ready output stream, or loads words from a valid/ready input
// stream into consecutive registers. Addresses wrap modulo 2**D.
module regfile_stream_port #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_stream_port_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    SEND,
    LOAD,
    DONE
  } state_t;

  state_t       state;
  logic [D-1:0] idx;
  logic [D:0]   remaining;
  logic [W-1:0] out_data_q;
  logic         busy_q;
  logic         done_q;
  logic         out_valid_q;
  logic         in_ready_q;

  logic         out_fire;
  logic         in_fire;
  logic         last_word;

  assign out_fire  = out_valid_q & bus.out_ready;
  assign in_fire   = in_ready_q & bus.in_valid;
  assign last_word = (remaining == (D+1)'(1));

  // Register-file and stream outputs; the write strobe is combinational so
  // the register is written on the very edge that completes the handshake.
  assign bus.rf_addr     = idx;
  assign bus.rf_wdata    = bus.in_data;
  assign bus.rf_write_en = in_fire;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.in_ready    = in_ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

  // Sequencer FSM with registered status/handshake outputs.
  // NOTE: state registers are updated with non-blocking assignments so every
  // branch below reads the pre-edge values of idx/remaining/state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      remaining   <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            idx       <= bus.start_addr;
            remaining <= bus.count;
            busy_q    <= 1'b1;
            if (bus.count == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else if (!bus.mode) begin
              state <= RD;
            end else begin
              state      <= LOAD;
              in_ready_q <= 1'b1;
            end
          end
        end

        RD: begin
          out_data_q  <= bus.rf_rdata;
          out_valid_q <= 1'b1;
          state       <= SEND;
        end

        SEND: begin
          if (out_fire) begin
            remaining   <= remaining - 1'b1;
            out_valid_q <= 1'b0;
            if (last_word) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= RD;
            end
          end
        end

        LOAD: begin
          if (in_fire) begin
            remaining <= remaining - 1'b1;
            if (last_word) begin
              state      <= DONE;
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state       <= IDLE;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_stream_port.sv
// Self-checking bench for regfile_stream_port: a behavioural register file
// sits on the rf_* side, and a plain array model predicts register contents,
// write addresses and dumped words.
module tb_regfile_stream_port;

  localparam int W     = 8;
  localparam int D     = 4;
  localparam int DEPTH = 1 << D;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  regfile_stream_port_if #(.W(W), .D(D)) bus ();

  regfile_stream_port #(.W(W), .D(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Register file seen by the sequencer: combinational read, write on edge.
  logic [W-1:0] rf_mem [DEPTH];
  assign bus.rf_rdata = rf_mem[bus.rf_addr];

  always @(posedge clk) begin
    if (bus.rf_write_en) rf_mem[bus.rf_addr] <= bus.rf_wdata;
  end

  // Reference contents of the register file.
  logic [W-1:0] model_regs [DEPTH];
  logic [W-1:0] load_words [$];

  int errors = 0;
  int checks = 0;
  int stray_writes = 0;
  logic load_window = 1'b0;

  // Any write strobe seen at an edge outside a load transfer is a fault.
  always @(posedge clk) begin
    if (bus.rf_write_en && !load_window) stray_writes++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start at a negedge; returns at the following negedge.
  task automatic do_start(input logic m, input int a, input int c);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.mode       = m;
    bus.start_addr = D'(a);
    bus.count      = (D+1)'(c);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // vmode: 0 = in_valid always high, 1 = random, 2 = toggling 1,0,1,...
  // poke_at: cycle at which a spurious start is pulsed (-1 = none).
  task automatic do_load(input int a, input int c, input int vmode, input int poke_at);
    int addr = a;
    int n = 0;
    int cyc = 0;
    logic v;
    logic [W-1:0] d;
    load_window = 1'b1;
    do_start(1'b1, a, c);
    check("load_busy", 32'(bus.busy), 1);
    while (n < c && cyc < 400) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = 1'($urandom_range(0, 1));
        default: v = (cyc % 2 == 0);
      endcase
      d = (n < load_words.size()) ? load_words[n] : W'($urandom);
      bus.in_valid = v;
      bus.in_data  = d;
      if (cyc == poke_at) begin
        bus.start      = 1'b1;
        bus.mode       = 1'b0;
        bus.start_addr = D'(9);
        bus.count      = (D+1)'(3);
      end else begin
        bus.start = 1'b0;
      end
      #1;
      check("load_in_ready", 32'(bus.in_ready), 1);
      check("load_write_en", 32'(bus.rf_write_en), 32'(v));
      if (v) begin
        check("load_addr", 32'(bus.rf_addr), 32'(addr % DEPTH));
        check("load_wdata", 32'(bus.rf_wdata), 32'(d));
        model_regs[addr % DEPTH] = d;
        addr++;
        n++;
      end
      cyc++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    if (n < c) check("load_timeout", 32'(n), 32'(c));
    check("load_done", 32'(bus.done), 1);
    check("load_done_busy", 32'(bus.busy), 1);
    check("load_done_in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    check("load_idle_done", 32'(bus.done), 0);
    check("load_idle_busy", 32'(bus.busy), 0);
    load_window = 1'b0;
  endtask

  // rmode: 0 = out_ready always high, 1 = random, 2 = low for 5 valid cycles.
  task automatic do_dump(input int a, input int c, input int rmode);
    int addr = a;
    int n = 0;
    int cyc = 0;
    int last_hs = -1;
    int stall = 0;
    logic r;
    logic have_held = 1'b0;
    logic [W-1:0] held = '0;
    do_start(1'b0, a, c);
    check("dump_busy", 32'(bus.busy), 1);
    while (n < c && cyc < 400) begin
      check("dump_write_en", 32'(bus.rf_write_en), 0);
      check("dump_in_ready", 32'(bus.in_ready), 0);
      case (rmode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = (stall >= 5);
      endcase
      if (bus.out_valid) begin
        if (have_held) check("dump_hold", 32'(bus.out_data), 32'(held));
        if (r) begin
          check("dump_data", 32'(bus.out_data), 32'(model_regs[addr % DEPTH]));
          if (rmode == 0 && last_hs >= 0) check("dump_spacing", 32'(cyc - last_hs), 2);
          last_hs   = cyc;
          have_held = 1'b0;
          addr++;
          n++;
        end else begin
          if (rmode == 2) check("dump_stall_addr", 32'(bus.rf_addr), 32'(addr % DEPTH));
          held      = bus.out_data;
          have_held = 1'b1;
          stall++;
        end
      end
      bus.out_ready = r;
      cyc++;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    if (n < c) check("dump_timeout", 32'(n), 32'(c));
    check("dump_done", 32'(bus.done), 1);
    check("dump_done_busy", 32'(bus.busy), 1);
    check("dump_done_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    check("dump_idle_done", 32'(bus.done), 0);
    check("dump_idle_busy", 32'(bus.busy), 0);
  endtask

  // count = 0: done in the cycle after start, no traffic at all.
  task automatic do_zero(input logic m);
    bus.in_valid = 1'b1;
    bus.in_data  = W'($urandom);
    do_start(m, int'($urandom_range(0, DEPTH - 1)), 0);
    #1;
    check("zero_done", 32'(bus.done), 1);
    check("zero_busy", 32'(bus.busy), 1);
    check("zero_out_valid", 32'(bus.out_valid), 0);
    check("zero_in_ready", 32'(bus.in_ready), 0);
    check("zero_write_en", 32'(bus.rf_write_en), 0);
    @(negedge clk);
    check("zero_idle_done", 32'(bus.done), 0);
    check("zero_idle_busy", 32'(bus.busy), 0);
    bus.in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 0);
    check({tag, "_write_en"}, 32'(bus.rf_write_en), 0);
    check({tag, "_rf_addr"}, 32'(bus.rf_addr), 0);
    check({tag, "_out_data"}, 32'(bus.out_data), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.mode       = 1'b0;
    bus.start_addr = '0;
    bus.count      = '0;
    bus.out_ready  = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rf_mem[i]     = W'($urandom);
      model_regs[i] = rf_mem[i];
    end
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Load then dump.
    load_words = {8'hA1, 8'hB2, 8'hC3};
    do_load(2, 3, 0, -1);
    load_words.delete();
    do_dump(2, 3, 0);

    // Wrap-around.
    load_words = {8'h11, 8'h22, 8'h33, 8'h44};
    do_load(14, 4, 0, -1);
    load_words.delete();
    do_dump(15, 2, 0);

    // Backpressure.
    do_dump(2, 2, 2);

    // Bubbles and count = 0.
    do_load(6, 3, 2, -1);
    do_zero(1'b0);
    do_zero(1'b1);

    // Full sweep with an ignored start mid-transfer.
    do_load(5, 16, 0, 7);
    do_dump(5, 16, 1);

    // Asynchronous reset in the middle of SEND.
    do_start(1'b0, 3, 2);
    b = 0;
    while (!bus.out_valid && b < 10) begin
      @(negedge clk);
      b++;
    end
    check("rst_send_valid", 32'(bus.out_valid), 1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_send");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_send_after");
    do_dump(3, 2, 0);

    // Asynchronous reset in the middle of LOAD: earlier words stay written.
    load_window = 1'b1;
    do_start(1'b1, 8, 4);
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'($urandom);
      #1;
      check("rst_load_write_en", 32'(bus.rf_write_en), 1);
      if (k < 2) begin
        model_regs[8 + k] = bus.in_data;
        @(negedge clk);
      end
    end
    #1 reset = 1'b1;
    #1 check_reset_outputs("rst_load");
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    load_window  = 1'b0;
    @(negedge clk);
    do_dump(8, 4, 0);

    // Randomized load/dump pairs.
    for (int t = 0; t < 6; t++) begin
      int a;
      int c;
      a = int'($urandom_range(0, DEPTH - 1));
      c = int'($urandom_range(1, DEPTH));
      do_load(a, c, 1, -1);
      do_dump(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, DEPTH)), 1);
    end

    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) check("final_reg", 32'(rf_mem[i]), 32'(model_regs[i]));
    check("stray_writes", 32'(stray_writes), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_stream_port.md
Name: regfile_stream_port

Overview:
- Access sequencer that sits on the other side of the single-port register file (one shared addr, write_en, data_in, data_out).
- Dump mode: reads a contiguous run of registers and emits them on a valid/ready output stream.
- Load mode: accepts words from a valid/ready input stream and writes them into consecutive registers.
- Used for debug, test-harness preload and register-state dump/restore around the processor core.

Parameters:
- W, 8, register data width (matches register file W)
- D, 4, register address width; register file depth is 2**D

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  1  0 = dump (read registers to out stream), 1 = load (in stream to registers); sampled with start
- start_addr  in  D  first register index; sampled with start
- count  in  D+1  number of words, 0..2**D; sampled with start
- busy  out  1  high from the cycle after an accepted start through the DONE state inclusive
- done  out  1  single-cycle pulse in DONE state
- rf_addr  out  D  register file address; equals internal index register
- rf_write_en  out  1  register file write enable (combinational, load mode only)
- rf_wdata  out  W  register file write data; equals in_data
- rf_rdata  in  W  register file combinational read data (its data_out)
- out_valid  out  1  dump stream valid
- out_ready  in  1  dump stream ready
- out_data  out  W  dump stream data (registered)
- in_valid  in  1  load stream valid
- in_ready  out  1  load stream ready
- in_data  in  W  load stream data

Behaviour:
- States: IDLE, RD (drive addr, capture), SEND (hold out word), LOAD (accept/write), DONE.
- Reset (async, immediate): state IDLE; idx, remaining and out_data cleared to 0. Outputs: busy 0, done 0, out_valid 0, in_ready 0, rf_write_en 0, rf_addr 0.
- IDLE with start=1:
  - idx <= start_addr; remaining <= count.
  - count == 0: go to DONE; no register access, no stream traffic.
  - Otherwise go to RD if mode=0, or LOAD if mode=1.
- start while not IDLE: ignored, no effect.
- RD (one cycle): rf_addr = idx; rf_write_en = 0; at the clock edge out_data <= rf_rdata, then go to SEND.
- SEND:
  - out_valid = 1; out_data held stable until handshake (out_valid & out_ready at a clock edge).
  - On handshake, remaining decrements. If remaining was 1, go to DONE; else idx <= idx+1 and go to RD.
  - Throughput: at most 1 word per 2 cycles.
- LOAD:
  - in_ready = 1; rf_addr = idx; rf_wdata = in_data; rf_write_en = in_valid (combinational). The register is written at the same edge as the handshake.
  - On handshake, remaining decrements. If remaining was 1, go to DONE; else idx <= idx+1 and stay in LOAD.
  - Throughput: 1 word per cycle.
  - in_valid=0 means no write and no state change.
- DONE: done = 1 and busy = 1 for exactly one cycle, then IDLE. done is never asserted outside DONE.
- Address wrap: idx increments modulo 2**D (e.g. D=4: 15 -> 0). count = 2**D covers every register exactly once.
- Stalls: out_ready or in_valid may stay low indefinitely; the block holds state with no timeout.
- Inactive outputs: rf_write_en = 0 in every state except LOAD. in_ready = 0 outside LOAD. out_valid = 0 outside SEND.
- rf_addr outside RD/LOAD equals idx; the register file must not be written there (rf_write_en = 0).
- Reset mid-operation: the current transfer is abandoned. Registers already written stay written; the pending out word is dropped (out_valid falls immediately).

Test Plan:
- Load then dump: load mode, start_addr=2, count=3, in_data 0xA1,0xB2,0xC3 with in_valid held high -> writes to regs 2,3,4 on 3 consecutive edges, done pulse 1 cycle later. Then dump same range with out_ready=1 -> out_data 0xA1,0xB2,0xC3 every 2nd cycle, done after third handshake.
- Wrap-around: load start_addr=14, count=4, data 0x11..0x44 -> regs 14,15,0,1 written. Dump with start_addr=15, count=2 -> 0x22, 0x33.
- Backpressure: dump count=2 with out_ready low for 5 cycles -> out_valid stays 1 with out_data constant. No idx advance until out_ready=1.
- Bubbles and count=0: load with in_valid toggling 1,0,1 -> writes only on valid cycles, rf_write_en=0 on the bubble. Start with count=0 -> done in the cycle after start, no rf_write_en, no out_valid.
- Full sweep and ignored start: load count=16, start_addr=5 -> all 16 regs written once, 5..15 then 0..4. A start pulse mid-transfer changes nothing.
- Async reset: assert reset mid-SEND between clock edges -> out_valid, busy, rf_write_en fall immediately. After release, state is IDLE and a new dump starts cleanly.
